// File: rtl/hazard_forward_unit.sv
// Purpose : control-side hazard unit for the ID-stage forwarding muxes; shadows
//           dst/RegWr/MemToReg of EX and MEM and raises forward selects plus a
//           one-cycle load-use stall/bubble.
// Latency : all outputs combinational from ID inputs and shadow state (same cycle);
//           shadow state advances one stage per clk edge.
// Backpressure: stall holds PC and IF/ID; bubble squashes the ID/EX control bits.
//
// Ports:
//   clk, rst                       rising-edge clock, asynchronous active-low reset
//   id_valid, id_rs, id_rt, id_rd  ID instruction validity and register fields
//   id_uses_rt, id_RegWr,          ID instruction decode: reads Rt, writes RF,
//   id_RegDst, id_MemToReg         selects Rd as destination, is a load
//   ex_forward_a/b                 select ALUout (instruction in EX) for operand A/B
//   mem_forward_a/b                select Dw (instruction in MEM) for operand A/B
//   stall, bubble                  load-use hazard indication
//   stat_stalls, stat_fwds         statistics counters (HAZARD_STATS_EN builds only)
//
// Build option: define HAZARD_STATS_EN to add the stall/forward statistics counters.
module hazard_forward_unit #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  id_valid,
    input  logic [REG_ADDR_W-1:0] id_rs,
    input  logic [REG_ADDR_W-1:0] id_rt,
    input  logic [REG_ADDR_W-1:0] id_rd,
    input  logic                  id_uses_rt,
    input  logic                  id_RegWr,
    input  logic                  id_RegDst,
    input  logic                  id_MemToReg,
    output logic                  ex_forward_a,
    output logic                  ex_forward_b,
    output logic                  mem_forward_a,
    output logic                  mem_forward_b,
    output logic                  stall,
    output logic                  bubble
`ifdef HAZARD_STATS_EN
    ,
    output logic [CNT_W-1:0]      stat_stalls,
    output logic [CNT_W-1:0]      stat_fwds
`endif
);

    // Elaboration-time sanity check on the configuration.
    if (REG_ADDR_W < 1 || CNT_W < 1) begin : g_param_check
        $error("hazard_forward_unit: REG_ADDR_W and CNT_W must be at least 1");
    end

    // ------------------------------------------------------------------
    // Shadow pipeline: the instruction in EX and the one in MEM.
    // ------------------------------------------------------------------
    logic [REG_ADDR_W-1:0] ex_dst_q,  ex_dst_d;
    logic                  ex_wr_q,   ex_wr_d;
    logic                  ex_ld_q,   ex_ld_d;
    logic [REG_ADDR_W-1:0] mem_dst_q, mem_dst_d;
    logic                  mem_wr_q,  mem_wr_d;

    logic [REG_ADDR_W-1:0] id_dst;
    logic                  lu;
    logic                  ex_hit_a, ex_hit_b;
    logic                  mem_hit_a, mem_hit_b;
    logic                  ex_fwd_a_raw, ex_fwd_b_raw;

    assign id_dst = id_RegDst ? id_rd : id_rt;

    // Source-register matches against each shadow stage. A stage only
    // counts as a writer when its write flag is set, and that flag is never
    // set for destination $0, so $0 reads are never forwarded.
    assign ex_hit_a  = id_valid & ex_wr_q  & (ex_dst_q  == id_rs);
    assign ex_hit_b  = id_valid & ex_wr_q  & id_uses_rt & (ex_dst_q  == id_rt);
    assign mem_hit_a = id_valid & mem_wr_q & (mem_dst_q == id_rs);
    assign mem_hit_b = id_valid & mem_wr_q & id_uses_rt & (mem_dst_q == id_rt);

    // A load in EX has no ALUout value to offer yet: any operand that needs
    // it must wait one cycle, after which the load sits in MEM and Dw
    // forwarding supplies it.
    assign lu = ex_ld_q & (ex_hit_a | ex_hit_b);

    // EX forwarding only for non-loads (a load match is the stall case).
    assign ex_fwd_a_raw = ex_hit_a & ~ex_ld_q;
    assign ex_fwd_b_raw = ex_hit_b & ~ex_ld_q;

    always_comb begin
        stall         = lu;
        bubble        = lu;
        // Everything is suppressed during the stall cycle: the ID
        // instruction is replayed next cycle and re-evaluated then.
        ex_forward_a  = ex_fwd_a_raw & ~lu;
        ex_forward_b  = ex_fwd_b_raw & ~lu;
        // Youngest value wins: MEM only when EX does not also match.
        mem_forward_a = mem_hit_a & ~ex_fwd_a_raw & ~lu;
        mem_forward_b = mem_hit_b & ~ex_fwd_b_raw & ~lu;
    end

    // ------------------------------------------------------------------
    // Next-state for the shadow pipeline. On a stall the held ID
    // instruction does not advance; a non-writing, non-load bubble enters
    // EX instead. MEM always takes whatever was in EX.
    // ------------------------------------------------------------------
    always_comb begin
        ex_dst_d  = id_dst;
        ex_wr_d   = id_valid & id_RegWr & (id_dst != '0) & ~lu;
        ex_ld_d   = id_MemToReg & ~lu;
        mem_dst_d = ex_dst_q;
        mem_wr_d  = ex_wr_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ex_dst_q  <= '0;
            ex_wr_q   <= 1'b0;
            ex_ld_q   <= 1'b0;
            mem_dst_q <= '0;
            mem_wr_q  <= 1'b0;
        end else begin
            ex_dst_q  <= ex_dst_d;
            ex_wr_q   <= ex_wr_d;
            ex_ld_q   <= ex_ld_d;
            mem_dst_q <= mem_dst_d;
            mem_wr_q  <= mem_wr_d;
        end
    end

`ifdef HAZARD_STATS_EN
    // ------------------------------------------------------------------
    // Statistics: one count per stall cycle, and one per cycle in which
    // any forward select is active (not one per operand). Free-running,
    // wrapping at 2^CNT_W.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] stat_stalls_q, stat_stalls_d;
    logic [CNT_W-1:0] stat_fwds_q,   stat_fwds_d;
    logic             any_fwd;

    assign any_fwd = ex_forward_a | ex_forward_b | mem_forward_a | mem_forward_b;

    always_comb begin
        stat_stalls_d = stat_stalls_q;
        stat_fwds_d   = stat_fwds_q;
        if (stall) begin
            stat_stalls_d = stat_stalls_q + CNT_W'(1);
        end
        if (any_fwd) begin
            stat_fwds_d = stat_fwds_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_stalls_q <= '0;
            stat_fwds_q   <= '0;
        end else begin
            stat_stalls_q <= stat_stalls_d;
            stat_fwds_q   <= stat_fwds_d;
        end
    end

    assign stat_stalls = stat_stalls_q;
    assign stat_fwds   = stat_fwds_q;
`endif

endmodule

// File: tb/tb_hazard_forward_unit.sv
module tb_hazard_forward_unit;

    localparam int RW = 5;
    localparam int CW = 32;

    logic          clk;
    logic          rst;
    logic          id_valid;
    logic [RW-1:0] id_rs, id_rt, id_rd;
    logic          id_uses_rt, id_RegWr, id_RegDst, id_MemToReg;
    logic          ex_forward_a, ex_forward_b, mem_forward_a, mem_forward_b;
    logic          stall, bubble;
`ifdef HAZARD_STATS_EN
    logic [CW-1:0] stat_stalls, stat_fwds;
`endif

    hazard_forward_unit #(.REG_ADDR_W(RW), .CNT_W(CW)) dut (
        .clk           (clk),
        .rst           (rst),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_rd         (id_rd),
        .id_uses_rt    (id_uses_rt),
        .id_RegWr      (id_RegWr),
        .id_RegDst     (id_RegDst),
        .id_MemToReg   (id_MemToReg),
        .ex_forward_a  (ex_forward_a),
        .ex_forward_b  (ex_forward_b),
        .mem_forward_a (mem_forward_a),
        .mem_forward_b (mem_forward_b),
        .stall         (stall),
        .bubble        (bubble)
`ifdef HAZARD_STATS_EN
        ,
        .stat_stalls   (stat_stalls),
        .stat_fwds     (stat_fwds)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: a list of the instructions that have left ID, the
    // newest at the back. The back entry is in EX, the one before it in MEM.
    // Operand resolution searches that list youngest-first for a writer.
    // ------------------------------------------------------------------
    typedef struct {
        bit writes;
        int dst;
        bit load;
    } instr_t;

    instr_t pipe[$];
    int unsigned m_stalls, m_fwds;
    bit e_exa, e_exb, e_mema, e_memb, e_stall;

    // observed outputs of the last cycle, for directed checks
    bit o_exa, o_exb, o_mema, o_memb, o_stall, o_bubble;
    logic [31:0] o_stalls_cnt;

    function automatic instr_t bubble_instr();
        instr_t b;
        b.writes = 0; b.dst = 0; b.load = 0;
        return b;
    endfunction

    task automatic model_reset();
        pipe.delete();
        pipe.push_back(bubble_instr());
        pipe.push_back(bubble_instr());
        m_stalls = 0;
        m_fwds   = 0;
    endtask

    // where: 0 none, 1 from EX (ALUout), 2 from MEM (Dw), 3 needs a load still in EX
    function automatic int resolve(input int src);
        for (int k = pipe.size() - 1; k >= 0; k--) begin
            if (pipe[k].writes && pipe[k].dst == src) begin
                if (k == pipe.size() - 1) return pipe[k].load ? 3 : 1;
                return 2;
            end
        end
        return 0;
    endfunction

    task automatic model_eval(input bit v, input int rs, input int rt, input bit urt);
        int wa, wb;
        wa = v ? resolve(rs) : 0;
        wb = (v && urt) ? resolve(rt) : 0;
        e_stall = (wa == 3) || (wb == 3);
        e_exa   = !e_stall && wa == 1;
        e_mema  = !e_stall && wa == 2;
        e_exb   = !e_stall && wb == 1;
        e_memb  = !e_stall && wb == 2;
    endtask

    task automatic model_step(input bit v, input int rs, input int rt, input int rd,
                              input bit rd_sel, input bit regwr, input bit m2r);
        instr_t n;
        int dst;
        dst = rd_sel ? rd : rt;
        if (e_stall) n = bubble_instr();
        else begin
            n.writes = v && regwr && dst != 0;
            n.dst    = dst;
            n.load   = m2r;
        end
        if (e_stall) m_stalls++;
        if (e_exa || e_exb || e_mema || e_memb) m_fwds++;
        pipe.push_back(n);
        void'(pipe.pop_front());
    endtask

    // One ID cycle: drive just after posedge, check at negedge, advance model at posedge.
    task automatic cyc(input bit v, input int rs, input int rt, input int rd, input bit urt,
                       input bit regwr, input bit rd_sel, input bit m2r);
        id_valid    = v;
        id_rs       = RW'(rs);
        id_rt       = RW'(rt);
        id_rd       = RW'(rd);
        id_uses_rt  = urt;
        id_RegWr    = regwr;
        id_RegDst   = rd_sel;
        id_MemToReg = m2r;
        @(negedge clk);
        model_eval(v, rs, rt, urt);
        chk("stall",  stall,         e_stall);
        chk("bubble", bubble,        e_stall);
        chk("ex_a",   ex_forward_a,  e_exa);
        chk("ex_b",   ex_forward_b,  e_exb);
        chk("mem_a",  mem_forward_a, e_mema);
        chk("mem_b",  mem_forward_b, e_memb);
        o_exa = ex_forward_a; o_exb = ex_forward_b;
        o_mema = mem_forward_a; o_memb = mem_forward_b;
        o_stall = stall; o_bubble = bubble;
`ifdef HAZARD_STATS_EN
        chk("stat_stalls", stat_stalls, m_stalls);
        chk("stat_fwds",   stat_fwds,   m_fwds);
        o_stalls_cnt = stat_stalls;
`else
        o_stalls_cnt = 0;
`endif
        @(posedge clk);
        model_step(v, rs, rt, rd, rd_sel, regwr, m2r);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_stall"},  stall,         0);
        chk({tag, "_bubble"}, bubble,        0);
        chk({tag, "_exa"},    ex_forward_a,  0);
        chk({tag, "_exb"},    ex_forward_b,  0);
        chk({tag, "_mema"},   mem_forward_a, 0);
        chk({tag, "_memb"},   mem_forward_b, 0);
    endtask

    // R-type: op rd, rs, rt
    task automatic rtype(input int rd, input int rs, input int rt);
        cyc(1, rs, rt, rd, 1, 1, 1, 0);
    endtask

    // lw rt, off(rs)
    task automatic lw(input int rt, input int rs);
        cyc(1, rs, rt, 0, 0, 1, 0, 1);
    endtask

    initial begin
        // reset with a busy-looking ID instruction: outputs must still be 0
        rst = 1'b0;
        id_valid = 1; id_rs = 3; id_rt = 3; id_rd = 3;
        id_uses_rt = 1; id_RegWr = 1; id_RegDst = 1; id_MemToReg = 1;
        model_reset();
        #3;
        chk_all_zero("reset");
`ifdef HAZARD_STATS_EN
        chk("reset_stat_stalls", stat_stalls, 0);
        chk("reset_stat_fwds",   stat_fwds,   0);
`endif
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;

        // 1: add $3,$1,$2 ; sub $4,$3,$5
        rtype(3, 1, 2);
        rtype(4, 3, 5);
        chk("t1_exa",  o_exa,  1);
        chk("t1_exb",  o_exb,  0);
        chk("t1_mema", o_mema, 0);
        chk("t1_memb", o_memb, 0);
        chk("t1_stall", o_stall, 0);

        // 2: add $3 ; unrelated ; or $6,$7,$3
        rtype(3, 1, 2);
        rtype(12, 10, 11);
        rtype(6, 7, 3);
        chk("t2_memb", o_memb, 1);
        chk("t2_exb",  o_exb,  0);
        chk("t2_mema", o_mema, 0);

        // 3: lw $8,0($1) ; add $9,$8,$8 (stalls once, then MEM forwards both)
        lw(8, 1);
        rtype(9, 8, 8);
        chk("t3_stall",  o_stall,  1);
        chk("t3_bubble", o_bubble, 1);
        rtype(9, 8, 8);
        chk("t3_stall_once", o_stall, 0);
        chk("t3_mema", o_mema, 1);
        chk("t3_memb", o_memb, 1);
        chk("t3_exa",  o_exa,  0);
        chk("t3_exb",  o_exb,  0);
`ifdef HAZARD_STATS_EN
        chk("t3_stat_stalls", o_stalls_cnt, 1);
`endif

        // 4: add $0,$1,$2 ; add $5,$0,$0
        rtype(0, 1, 2);
        rtype(5, 0, 0);
        chk("t4_exa", o_exa, 0);
        chk("t4_exb", o_exb, 0);
        chk("t4_mema", o_mema, 0);
        chk("t4_memb", o_memb, 0);
        chk("t4_stall", o_stall, 0);

        // 5: add $3 ; add $3 ; sub $4,$3,$3 -> EX wins
        rtype(3, 1, 2);
        rtype(3, 5, 6);
        rtype(4, 3, 3);
        chk("t5_exa", o_exa, 1);
        chk("t5_exb", o_exb, 1);
        chk("t5_mema", o_mema, 0);
        chk("t5_memb", o_memb, 0);

        // 6: reset asserted during the load-use stall
        lw(8, 1);
        id_valid = 1; id_rs = 8; id_rt = 8; id_rd = 9;
        id_uses_rt = 1; id_RegWr = 1; id_RegDst = 1; id_MemToReg = 0;
        #1;
        chk("t6_stall_before", stall, 1);
        chk("t6_bubble_before", bubble, 1);
        rst = 1'b0;
        #1;
        chk_all_zero("t6_async");
        @(posedge clk);
        #1;
        rst = 1'b1;
        model_reset();
        rtype(9, 8, 8);
        chk("t6_after_stall", o_stall, 0);
        chk("t6_after_exa", o_exa, 0);
        chk("t6_after_mema", o_mema, 0);
        chk("t6_after_memb", o_memb, 0);

        // randomized traffic over a small register set to provoke matches
        for (int i = 0; i < 3000; i++) begin
            int kind;
            if ($urandom_range(0, 199) == 0) begin
                rst = 1'b0;
                #1;
                chk_all_zero("rand_async");
                @(posedge clk);
                #1;
                rst = 1'b1;
                model_reset();
            end
            kind = $urandom_range(0, 3);
            cyc($urandom_range(0, 9) != 0,
                $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
                kind != 1,                 // uses_rt
                $urandom_range(0, 5) != 0, // RegWr
                kind == 0 || kind == 3,    // RegDst
                kind == 1);                // MemToReg
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
